// File: rtl/vga_fb_pkg.sv
// Shared constants, controller state encoding and the framebuffer address helper
// used by the VGA double-buffered framebuffer.
package vga_fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 6;

    localparam logic [9:0] OFFSCREEN = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } fb_state_t;

    // fy*160 + fx without a multiplier: 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] fy,
                                                  input logic [ADDR_W-1:0] fx);
        return (fy << 7) + (fy << 5) + fx;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Two-bank simple dual-port framebuffer store: one write port, one read port
// with a registered read. Contents are never reset.
module fb_ram
    import vga_fb_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic               wr_bank,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               rd_bank,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_data
);

    logic [COLOR_W-1:0] mem [2][FB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/vga_framebuffer.sv
// Double-buffered 160x120 framebuffer scaled 4x onto the VGA raster, with a
// clear engine and a swap that is deferred to the start of vertical blanking.
module vga_framebuffer #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] vga_rx,
    input  logic [9:0] vga_ry,
    input  logic       active,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [5:0] wr_color,
    input  logic       clear_req,
    input  logic [5:0] clear_color,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       front_sel,
    output logic       busy
);

    import vga_fb_pkg::*;

    fb_state_t          state, state_next;
    logic               init_done;
    logic               front_sel_next, swap_pending_next;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_next;
    logic [COLOR_W-1:0] clr_color, clr_color_next;
    logic [9:0]         ry_q;
    logic               vis_q;
    logic [COLOR_W-1:0] rgb_q;
    logic               vblank_start;
    logic               wr_in_range, wr_fire;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr, rd_addr;
    logic [COLOR_W-1:0] ram_wdata, rd_data;

    assign vblank_start = (ry_q != OFFSCREEN) && (vga_ry == OFFSCREEN);
    // init_done keeps wr_ready low while reset is held and for no longer.
    assign wr_ready     = init_done && (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign wr_in_range  = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
    assign wr_fire      = wr_valid && wr_ready && wr_in_range;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        swap_pending_next = swap_pending;
        front_sel_next    = front_sel;
        clr_cnt_next      = clr_cnt;
        clr_color_next    = clr_color;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    clr_color_next = clear_color;
                    clr_cnt_next   = '0;
                    state_next     = ST_CLEAR;
                    if (swap_req) swap_pending_next = 1'b1;
                end else if (swap_req) begin
                    swap_pending_next = 1'b1;
                    state_next        = ST_SWAP_WAIT;
                end
            end
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (swap_req) swap_pending_next = 1'b1;
                // A swap requested on the final clear cycle still counts.
                if (clr_cnt == ADDR_W'(FB_DEPTH - 1)) begin
                    state_next = (swap_pending || swap_req) ? ST_SWAP_WAIT : ST_IDLE;
                end
            end
            ST_SWAP_WAIT: begin
                if (vblank_start) begin
                    front_sel_next    = !front_sel;
                    swap_pending_next = 1'b0;
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            init_done    <= 1'b0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            clr_cnt      <= '0;
            clr_color    <= '0;
            ry_q         <= '0;
            vis_q        <= 1'b0;
            rgb_q        <= '0;
        end else begin
            init_done    <= 1'b1;
            front_sel    <= front_sel_next;
            swap_pending <= swap_pending_next;
            clr_cnt      <= clr_cnt_next;
            clr_color    <= clr_color_next;
            ry_q         <= vga_ry;
            vis_q        <= active && (vga_rx != OFFSCREEN) && (vga_ry != OFFSCREEN);
            rgb_q        <= vis_q ? rd_data : '0;
        end
    end

    // The clear engine owns the write port; host writes only land in IDLE.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fb_addr(ADDR_W'(wr_y), ADDR_W'(wr_x));
        ram_wdata = wr_color;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = clr_color;
        end else if (wr_fire) begin
            ram_we = 1'b1;
        end
    end

    assign rd_addr = fb_addr(ADDR_W'(vga_ry >> SCALE_SHIFT), ADDR_W'(vga_rx >> SCALE_SHIFT));

    fb_ram u_ram (
        .clk     (CLOCK_50),
        .we      (ram_we),
        .wr_bank (!front_sel),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_bank (front_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign R = rgb_q[5:4];
    assign G = rgb_q[3:2];
    assign B = rgb_q[1:0];

endmodule

// File: tb/tb_vga_framebuffer.sv
// Randomised and directed bench for vga_framebuffer against a behavioural
// model of two banks, the controller rules and the 2-cycle colour pipeline.
`timescale 1ns/1ps
module tb_vga_framebuffer;

    import vga_fb_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_SWAPW = 2;

    // ---------------- clock / reset ----------------
    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    logic reset = 1'b1;

    logic [9:0] vga_rx = '0, vga_ry = '0;
    logic       active = 1'b0;
    logic [1:0] R, G, B;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_x = '0;
    logic [6:0] wr_y = '0;
    logic [5:0] wr_color = '0;
    logic       clear_req = 1'b0;
    logic [5:0] clear_color = '0;
    logic       swap_req = 1'b0;
    logic       swap_pending, front_sel, busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    vga_framebuffer dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .vga_rx       (vga_rx),
        .vga_ry       (vga_ry),
        .active       (active),
        .R            (R),
        .G            (G),
        .B            (B),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_color     (wr_color),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mem entries: -1 = never written, else the 6-bit colour.
    int         mem [2][FB_DEPTH];
    int         m_state = M_IDLE;
    bit         m_front = 1'b0;
    bit         m_pend  = 1'b0;
    bit         m_init  = 1'b0;
    int         m_cnt   = 0;
    int         m_color = 0;
    int         m_ry_prev = 0;
    logic [6:0] m_rgb = 7'h40;     // bit 6 = value is known
    logic [6:0] exp_q [$];

    always @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            m_state = M_IDLE; m_front = 1'b0; m_pend = 1'b0; m_init = 1'b0;
            m_ry_prev = 0;
            exp_q.delete();
            exp_q.push_back(7'h40);
            m_rgb = 7'h40;
        end else begin
            logic [6:0] s;
            int a, back;
            bit vb;
            s = 7'h40;
            if (active && vga_rx != 10'd1023 && vga_ry != 10'd1023) begin
                a = (int'(vga_ry) / 4) * 160 + int'(vga_rx) / 4;
                if (a < FB_DEPTH) begin
                    if (mem[m_front ? 1 : 0][a] < 0) s = 7'h00;
                    else s = {1'b1, 6'(mem[m_front ? 1 : 0][a])};
                end else begin
                    s = 7'h00;
                end
            end
            exp_q.push_back(s);
            m_rgb = exp_q.pop_front();

            vb = (m_ry_prev != 1023) && (int'(vga_ry) == 1023);
            m_ry_prev = int'(vga_ry);
            back = m_front ? 0 : 1;
            case (m_state)
                M_IDLE: begin
                    if (m_init && wr_valid && int'(wr_x) < 160 && int'(wr_y) < 120)
                        mem[back][int'(wr_y) * 160 + int'(wr_x)] = int'(wr_color);
                    if (clear_req) begin
                        m_color = int'(clear_color); m_cnt = 0; m_state = M_CLEAR;
                        if (swap_req) m_pend = 1'b1;
                    end else if (swap_req) begin
                        m_pend = 1'b1; m_state = M_SWAPW;
                    end
                end
                M_CLEAR: begin
                    mem[back][m_cnt] = m_color;
                    if (swap_req) m_pend = 1'b1;
                    if (m_cnt == FB_DEPTH - 1) m_state = m_pend ? M_SWAPW : M_IDLE;
                    m_cnt++;
                end
                default: begin
                    if (vb) begin
                        m_front = !m_front; m_pend = 1'b0; m_state = M_IDLE;
                    end
                end
            endcase
            m_init = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("wr_ready", int'(wr_ready), int'(m_init && m_state == M_IDLE));
            check("busy", int'(busy), int'(m_state != M_IDLE));
            check("front_sel", int'(front_sel), int'(m_front));
            check("swap_pending", int'(swap_pending), int'(m_pend));
            if (m_rgb[6]) check("rgb", int'({R, G, B}), int'(m_rgb[5:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    task automatic set_pix(input int x, input int y, input bit act);
        vga_rx = 10'(x); vga_ry = 10'(y); active = act;
    endtask

    task automatic do_write(input int x, input int y, input logic [5:0] c);
        @(negedge CLOCK_50);
        wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_color = c;
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge CLOCK_50);
        swap_req = 1'b1; set_pix(0, 100, 1'b0);
        @(negedge CLOCK_50);
        swap_req = 1'b0;
    endtask

    task automatic vblank();
        @(negedge CLOCK_50);
        set_pix(1023, 479, 1'b0);
        @(negedge CLOCK_50);
        set_pix(1023, 1023, 1'b0);
        @(negedge CLOCK_50);
    endtask

    task automatic read_pix(input int x, input int y, input bit act, output logic [5:0] v);
        @(negedge CLOCK_50);
        set_pix(x, y, act);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        v = {R, G, B};
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [5:0] v;
        int n, bad, f0, r;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < FB_DEPTH; a++) mem[b][a] = -1;

        #1 reset = 1'b0;
        cmp_en = 1'b1;
        cyc(3);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_front_sel", int'(front_sel), 0);
        check("rst_swap_pending", int'(swap_pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rgb", int'({R, G, B}), 0);
        #2 reset = 1'b1;
        #1 check("ready_before_first_edge", int'(wr_ready), 0);
        @(posedge CLOCK_50);
        #1 check("ready_after_first_edge", int'(wr_ready), 1);

        // write (10,5) red, swap it to the front, scan its 4x4 screen block
        do_write(10, 5, 6'b110000);
        pulse_swap();
        vblank();
        check("s1_front_sel", int'(front_sel), 1);
        for (int k = 0; k < 18; k++) begin
            @(negedge CLOCK_50);
            if (k >= 2) begin
                check("s1_pixel", int'({R, G, B}), 6'b110000);
                check("s1_model_pin", int'(m_rgb), 7'h70);
            end
            if (k < 16) set_pix(40 + k % 4, 20 + k / 4, 1'b1);
            else active = 1'b0;
        end

        // random writes, reads and swaps over a small corner of the buffer
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLOCK_50);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_x = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 7));
            wr_y = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 7));
            wr_color = 6'($urandom);
            swap_req = ($urandom_range(0, 60) == 0);
            r = int'($urandom_range(0, 9));
            if (r == 0) set_pix(1023, 1023, 1'b0);
            else begin
                set_pix(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
                if (r == 1) vga_rx = 10'd1023;
            end
        end
        @(negedge CLOCK_50);
        wr_valid = 1'b0; swap_req = 1'b0; set_pix(0, 200, 1'b0);

        // clear to blue: exact busy length, writes refused throughout
        wait_idle(2000);
        @(negedge CLOCK_50);
        clear_req = 1'b1; clear_color = 6'b000011;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_color = 6'b111111;
        n = 0; bad = 0;
        while (busy && n < 25000) begin
            n++;
            if (wr_ready) bad++;
            @(negedge CLOCK_50);
        end
        wr_valid = 1'b0;
        check("clear_busy_cycles", n, 19200);
        check("clear_wr_ready_low", bad, 0);
        f0 = int'(front_sel);
        pulse_swap();
        vblank();
        check("clear_swap_toggle", int'(front_sel), 1 - f0);
        bad = 0;
        for (int k = 0; k < FB_DEPTH + 2; k++) begin
            @(negedge CLOCK_50);
            if (k >= 2 && {R, G, B} != 6'b000011) bad++;
            if (k < FB_DEPTH)
                set_pix((k % 160) * 4 + int'($urandom_range(0, 3)), (k / 160) * 4 + int'($urandom_range(0, 3)), 1'b1);
            else active = 1'b0;
        end
        check("clear_readback_blue", bad, 0);

        // swap requested mid-frame waits for the 479 -> 1023 transition
        wait_idle(100);
        f0 = int'(front_sel);
        @(negedge CLOCK_50);
        swap_req = 1'b1; set_pix(0, 100, 1'b0);
        bad = 0;
        for (int y = 101; y <= 479; y++) begin
            @(negedge CLOCK_50);
            swap_req = 1'b0;
            if (int'(front_sel) != f0 || !swap_pending) bad++;
            vga_ry = 10'(y);
        end
        @(negedge CLOCK_50);
        if (int'(front_sel) != f0 || !swap_pending) bad++;
        check("swap_held_visible", bad, 0);
        vga_ry = 10'd1023;
        @(negedge CLOCK_50);
        check("swap_toggle_vblank", int'(front_sel), 1 - f0);
        check("swap_pending_cleared", int'(swap_pending), 0);

        // out-of-range writes would alias onto (40,6) and (10,1) if stored
        do_write(200, 5, 6'b111111);
        do_write(170, 0, 6'b111111);
        pulse_swap();
        vblank();
        read_pix(160, 24, 1'b1, v);
        check("oob_x200_no_store", int'(v), 6'b000011);
        read_pix(41, 5, 1'b1, v);
        check("oob_x170_no_store", int'(v), 6'b000011);
        read_pix(160, 24, 1'b0, v);
        check("blank_active0", int'(v), 0);
        read_pix(1023, 24, 1'b1, v);
        check("blank_rx1023", int'(v), 0);

        // simultaneous clear and swap: CLEAR, SWAP_WAIT, one toggle
        wait_idle(100);
        f0 = int'(front_sel);
        @(negedge CLOCK_50);
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 6'b001100; set_pix(0, 200, 1'b0);
        @(negedge CLOCK_50);
        clear_req = 1'b0; swap_req = 1'b0;
        check("sim_state_clear", int'(dut.state), int'(ST_CLEAR));
        check("sim_pending_set", int'(swap_pending), 1);
        n = 0;
        while (dut.state == ST_CLEAR && n < 25000) begin
            n++;
            @(negedge CLOCK_50);
        end
        check("sim_clear_cycles", n, 19200);
        cyc(20);
        check("sim_state_swap_wait", int'(dut.state), int'(ST_SWAP_WAIT));
        check("sim_front_before_vblank", int'(front_sel), f0);
        vblank();
        check("sim_front_toggled", int'(front_sel), 1 - f0);
        check("sim_state_idle", int'(dut.state), int'(ST_IDLE));
        read_pix(300, 300, 1'b1, v);
        check("sim_front_green", int'(v), 6'b001100);
        check("sim_single_toggle", int'(front_sel), 1 - f0);

        // reset in the middle of a clear with a swap already pending
        if (!front_sel) begin
            pulse_swap();
            vblank();
        end
        @(negedge CLOCK_50);
        clear_req = 1'b1; clear_color = 6'b110011; set_pix(0, 200, 1'b0);
        @(negedge CLOCK_50);
        clear_req = 1'b0; swap_req = 1'b1;
        @(negedge CLOCK_50);
        swap_req = 1'b0;
        cyc(4998);
        check("mid_clear_pending", int'(swap_pending), 1);
        check("mid_clear_front", int'(front_sel), 1);
        #3 reset = 1'b0;
        #1;
        check("async_rst_rgb", int'({R, G, B}), 0);
        check("async_rst_wr_ready", int'(wr_ready), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_pending", int'(swap_pending), 0);
        check("async_rst_front", int'(front_sel), 0);
        cyc(3);
        #2 reset = 1'b1;
        @(negedge CLOCK_50);
        check("post_rst_state", int'(dut.state), int'(ST_IDLE));
        check("post_rst_wr_ready", int'(wr_ready), 1);
        vblank();
        check("post_rst_no_swap", int'(front_sel), 0);
        read_pix(0, 0, 1'b1, v);
        check("partial_clear_kept", int'(v), 6'b110011);
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
